// File: rtl/uart_tx_arb.sv
// Line-atomic two-requester arbiter in front of the UART_COM transmit port.
// The holder of the grant keeps it until it sends TERM or goes silent for TIMEOUT cycles.
module uart_tx_arb #(
    parameter logic [7:0]  TERM    = 8'h0A,
    parameter int unsigned TIMEOUT = 100000,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s0_data,
    input  logic       s0_valid,
    output logic       s0_ready,
    input  logic [7:0] s1_data,
    input  logic       s1_valid,
    output logic       s1_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [1:0] grant,
    output logic       timeout_pulse
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrant0 = 2'd1,
        StGrant1 = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CntMax  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic hold_id;
    logic hold_xfer;
    logic hold_term;

    // Grant-path mux: readies depend only on m_ready and registered state.
    always_comb begin
        m_data   = 8'h00;
        m_valid  = 1'b0;
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        case (state_q)
            StGrant0: begin
                m_data   = s0_data;
                m_valid  = s0_valid;
                s0_ready = m_ready;
            end
            StGrant1: begin
                m_data   = s1_data;
                m_valid  = s1_valid;
                s1_ready = m_ready;
            end
            default: begin
                m_data  = 8'h00;
                m_valid = 1'b0;
            end
        endcase
    end

    assign grant     = {state_q == StGrant1, state_q == StGrant0};
    assign hold_id   = (state_q == StGrant1);
    assign hold_xfer = m_valid && m_ready;
    assign hold_term = hold_xfer && (m_data == TERM);

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        timeout_pulse = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (s0_valid && s1_valid) begin
                    // Round-robin on a tie: favour whoever did not hold last.
                    state_d = last_q ? StGrant0 : StGrant1;
                end else if (s0_valid) begin
                    state_d = StGrant0;
                end else if (s1_valid) begin
                    state_d = StGrant1;
                end
            end
            StGrant0, StGrant1: begin
                if (hold_term) begin
                    // Terminator wins over a coincident timeout.
                    state_d = StIdle;
                    last_d  = hold_id;
                    cnt_d   = '0;
                end else if (m_valid) begin
                    // A stalled but valid holder is never timed out.
                    cnt_d = '0;
                end else if (cnt_q == CntLast) begin
                    state_d       = StIdle;
                    last_d        = hold_id;
                    cnt_d         = '0;
                    timeout_pulse = 1'b1;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: expected bytes are queued per test and a
// negedge monitor checks every m_valid/m_ready transfer against the queue.
module tb_uart_tx_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s0_data = 8'h00;
    logic       s0_valid = 1'b0;
    logic       s0_ready;
    logic [7:0] s1_data = 8'h00;
    logic       s1_valid = 1'b0;
    logic       s1_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [1:0] grant;
    logic       timeout_pulse;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // {src, byte}; src 0 expects grant 01, src 1 expects grant 10
    logic [8:0] exp_q[$];
    int         xfer_cyc[$];

    uart_tx_arb #(
        .TERM    (8'h0A),
        .TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s0_data       (s0_data),
        .s0_valid      (s0_valid),
        .s0_ready      (s0_ready),
        .s1_data       (s1_data),
        .s1_valid      (s1_valid),
        .s1_ready      (s1_ready),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .grant         (grant),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: a transfer completes at the following posedge.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst && m_valid && m_ready) begin
            xfer_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_xfer: got data %0h grant %0b expected nothing", m_data,
                         grant);
            end else begin
                e = exp_q.pop_front();
                if (m_data !== e[7:0] || grant !== (e[8] ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL xfer: got data %0h grant %0b expected data %0h grant %0b",
                             m_data, grant, e[7:0], (e[8] ? 2'b10 : 2'b01));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic src, input logic [31:0] line, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({src, line[31-8*i -: 8]});
    endtask

    // Present a line byte by byte, holding each byte until its handshake.
    task automatic drive(input int src, input logic [31:0] line, input int n);
        logic [7:0] b;
        int         w;
        bit         done;
        for (int i = 0; i < n; i++) begin
            b = line[31-8*i -: 8];
            if (src == 0) begin
                s0_data  = b;
                s0_valid = 1'b1;
            end else begin
                s1_data  = b;
                s1_valid = 1'b1;
            end
            w    = 0;
            done = 0;
            while (!done) begin
                @(negedge clk);
                if ((src == 0) ? s0_ready : s1_ready) begin
                    done = 1;
                end else if (++w > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL drive_wait: src %0d byte %0d got no ready expected ready",
                             src, i);
                    done = 1;
                end
            end
            step();
        end
        if (src == 0) begin
            s0_valid = 1'b0;
            s0_data  = 8'h00;
        end else begin
            s1_valid = 1'b0;
            s1_data  = 8'h00;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        m_ready  = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] at_crlf[4];
        at_crlf[0] = 8'h41;
        at_crlf[1] = 8'h54;
        at_crlf[2] = 8'h0D;
        at_crlf[3] = 8'h0A;

        // Reset values
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 8'h00);
        chk("rst_s0_ready", s0_ready, 1'b0);
        chk("rst_s1_ready", s1_ready, 1'b0);
        chk("rst_timeout", timeout_pulse, 1'b0);
        do_reset();

        // Single requester "AT\r\n"
        push(1'b0, 32'h41540D0A, 4);
        s0_valid = 1'b1;
        s0_data  = at_crlf[0];
        @(negedge clk);
        chk("t1_idle_grant", grant, 2'b00);
        chk("t1_idle_ready", s0_ready, 1'b0);
        step();
        chk("t1_grant", grant, 2'b01);
        for (int i = 0; i < 4; i++) begin
            s0_data = at_crlf[i];
            @(negedge clk);
            chk("t1_consecutive", s0_ready, 1'b1);
            step();
        end
        s0_valid = 1'b0;
        chk("t1_release", grant, 2'b00);

        // Contention from reset: s0 line first, one idle cycle, then s1
        do_reset();
        xfer_cyc.delete();
        push(1'b0, 32'h41540A00, 3);
        push(1'b1, 32'h68690A00, 3);
        fork
            drive(0, 32'h41540A00, 3);
            drive(1, 32'h68690A00, 3);
        join
        if (xfer_cyc.size() >= 4) begin
            chk("t2_s0_back_to_back", xfer_cyc[2] - xfer_cyc[0], 2);
            chk("t2_idle_gap", xfer_cyc[3] - xfer_cyc[2], 2);
        end else begin
            chk("t2_xfer_count", xfer_cyc.size(), 6);
        end
        // last = s1, so the next tie goes to s0
        push(1'b0, 32'h0A000000, 1);
        push(1'b1, 32'h0A000000, 1);
        fork
            drive(0, 32'h0A000000, 1);
            drive(1, 32'h0A000000, 1);
        join
        // s0 alone sets last = s0, so the following tie goes to s1
        push(1'b0, 32'h0A000000, 1);
        drive(0, 32'h0A000000, 1);
        push(1'b1, 32'h0A000000, 1);
        push(1'b0, 32'h0A000000, 1);
        fork
            drive(0, 32'h0A000000, 1);
            drive(1, 32'h0A000000, 1);
        join

        // Backpressure on an s1 line with a long stall
        push(1'b1, 32'h6F6B0A00, 3);
        s1_valid = 1'b1;
        s1_data  = 8'h6F;
        step();
        chk("t3_grant", grant, 2'b10);
        @(negedge clk);
        chk("t3_ready_hi", s1_ready, 1'b1);
        step();
        s1_data = 8'h6B;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_data", m_data, 8'h6B);
            chk("t3_ready_mirror", s1_ready, 1'b0);
            chk("t3_no_timeout", timeout_pulse, 1'b0);
            chk("t3_keep_grant", grant, 2'b10);
            step();
        end
        m_ready = 1'b1;
        @(negedge clk);
        chk("t3_ready_resume", s1_ready, 1'b1);
        step();
        s1_data = 8'h0A;
        @(negedge clk);
        chk("t3_ready_term", s1_ready, 1'b1);
        step();
        s1_valid = 1'b0;
        chk("t3_release", grant, 2'b00);

        // Timeout with s1 pending
        push(1'b0, 32'h41000000, 1);
        push(1'b1, 32'h0A000000, 1);
        s0_valid = 1'b1;
        s0_data  = 8'h41;
        s1_valid = 1'b1;
        s1_data  = 8'h0A;
        step();
        chk("t4_grant", grant, 2'b01);
        @(negedge clk);
        chk("t4_ready", s0_ready, 1'b1);
        step();
        s0_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_pulse", timeout_pulse, (i == 3) ? 1'b1 : 1'b0);
            chk("t4_hold", grant, 2'b01);
            step();
        end
        chk("t4_released", grant, 2'b00);
        chk("t4_pulse_once", timeout_pulse, 1'b0);
        step();
        chk("t4_s1_granted", grant, 2'b10);
        @(negedge clk);
        chk("t4_s1_ready", s1_ready, 1'b1);
        step();
        s1_valid = 1'b0;

        // Terminator arriving on the cycle the timeout would fire
        push(1'b0, 32'h410A0000, 2);
        s0_valid = 1'b1;
        s0_data  = 8'h41;
        step();
        @(negedge clk);
        chk("t5_ready", s0_ready, 1'b1);
        step();
        s0_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t5_idle_pulse", timeout_pulse, 1'b0);
            step();
        end
        s0_valid = 1'b1;
        s0_data  = 8'h0A;
        @(negedge clk);
        chk("t5_term_pulse", timeout_pulse, 1'b0);
        chk("t5_term_ready", s0_ready, 1'b1);
        step();
        s0_valid = 1'b0;
        chk("t5_release", grant, 2'b00);
        chk("t5_pulse_after", timeout_pulse, 1'b0);

        // Reset mid-line; last is s0 here, so the post-reset tie proves last reset to 1
        push(1'b0, 32'h41540000, 2);
        s0_valid = 1'b1;
        s0_data  = 8'h41;
        step();
        @(negedge clk);
        step();
        s0_data = 8'h54;
        @(negedge clk);
        step();
        s0_data = 8'h0D;
        #3;
        rst = 1'b1;
        #1;
        chk("t6_grant", grant, 2'b00);
        chk("t6_m_valid", m_valid, 1'b0);
        chk("t6_timeout", timeout_pulse, 1'b0);
        chk("t6_s0_ready", s0_ready, 1'b0);
        s0_valid = 1'b0;
        step();
        rst = 1'b0;
        push(1'b0, 32'h41540D0A, 4);
        push(1'b1, 32'h0A000000, 1);
        fork
            drive(0, 32'h41540D0A, 4);
            drive(1, 32'h0A000000, 1);
        join
        repeat (2) step();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Shares one UART_COM transmit channel between two byte-stream requesters: the AT-command ROM streamer (s0) and the monitor-UART passthrough (s1).
- Arbitration is line-atomic. Once a requester holds the grant, it keeps it until it transfers the terminator byte, or until it goes silent for a timeout period. Lines from the two sources therefore never interleave on the PMOD ESP32 link.
- Sits between the command sequencer/monitor RX path and the PMOD UART_COM tx_data/tx_valid/tx_ready port.

Parameters:
- TERM, 8'h0A, terminator byte that ends a line and releases the grant.
- TIMEOUT, 100000, number of consecutive holder-idle cycles (holder valid low) before the grant is forcibly released.
- CNT_W, $clog2(TIMEOUT+1), width of the idle counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- s0_data  in  8  requester 0 byte (command ROM streamer).
- s0_valid  in  1  requester 0 byte valid.
- s0_ready  out  1  requester 0 byte accepted.
- s1_data  in  8  requester 1 byte (monitor passthrough).
- s1_valid  in  1  requester 1 byte valid.
- s1_ready  out  1  requester 1 byte accepted.
- m_data  out  8  byte to UART_COM tx_data.
- m_valid  out  1  to UART_COM tx_valid.
- m_ready  in  1  from UART_COM tx_ready.
- grant  out  2  one-hot current owner; 2'b00 when idle.
- timeout_pulse  out  1  one-cycle pulse when a grant is released by timeout.

Behaviour:
- Handshake: valid/ready. A byte transfers on a cycle where valid and ready are both high. Requesters hold valid and data stable until ready. The arbiter never drops or duplicates a byte.
- State machine: IDLE, GRANT0, GRANT1. Registered state and grant; grant = {state==GRANT1, state==GRANT0}.
- Reset values:
  - state = IDLE, grant = 00, last = 1 (so s0 wins the first tie).
  - idle counter = 0, timeout_pulse = 0.
  - m_valid = 0, m_data = 0, s0_ready = 0, s1_ready = 0.
- IDLE:
  - No requester valid: stay in IDLE.
  - Only sX valid: go to GRANTX next cycle.
  - Both valid: grant the requester other than last (round-robin).
  - No transfer occurs in IDLE, so arbitration costs exactly one cycle of latency.
- GRANTx datapath (combinational, zero added latency):
  - m_data = sx_data, m_valid = sx_valid, sx_ready = m_ready.
  - The non-granted sN_ready is 0.
- In IDLE, m_valid = 0, m_data = 0, and both readies are 0.
- Release on terminator: a transfer with sx_data == TERM causes the next state to be IDLE and sets last = x. A TERM byte transfers normally.
- Idle counter while in GRANTx:
  - Cleared when sx_valid is high; incremented when sx_valid is low.
  - Saturates at TIMEOUT.
  - When the counter == TIMEOUT-1 and sx_valid is low: go to IDLE, set last = x, pulse timeout_pulse for 1 cycle.
  - If sx_valid is high but m_ready is low (UART busy), there is no timeout. Stalling is legal.
- Counter clears on every grant entry and on return to IDLE.
- Simultaneous events: a TERM transfer takes precedence over timeout in the same cycle; timeout_pulse stays 0.
- Back-to-back lines: after a release, the other requester, if valid, is granted on the IDLE cycle's next edge. A continuous requester alone re-acquires the grant after one IDLE cycle.
- Reset mid-line: immediate return to IDLE with all outputs at their reset values. The partial line is abandoned. A requester must not assume its in-flight byte transferred unless its handshake completed before reset.
- No combinational path from m_ready to any valid. sx_ready depends on m_ready and registered state only.

Test Plan:
- Single requester: s0 sends "AT\r\n" (41 54 0D 0A) with m_ready=1.
  - Required: grant = 01 one cycle after s0_valid rises.
  - m_data sequence 41,54,0D,0A on 4 consecutive cycles.
  - grant = 00 on the cycle after 0A transfers.
- Contention: s0 and s1 both valid from reset with lines "AT\n" and "hi\n".
  - Required: s0 is served first, all 3 bytes with no s1 byte interleaved.
  - Then one IDLE cycle, then s1 is served.
  - The next tie goes to s0 (round-robin check).
- Backpressure: m_ready toggles 1,0,0,1 during an s1 line.
  - Required: m_data holds stable while m_ready=0.
  - s1_ready mirrors m_ready.
  - No timeout even with TIMEOUT=4.
- Timeout (TIMEOUT=4): s0 sends 41 then drops valid for 4 cycles.
  - Required: timeout_pulse high for 1 cycle at the 4th idle cycle.
  - grant = 00 on the next cycle.
  - A pending s1 is granted next.
- Terminator coincident with timeout (TIMEOUT=4): s0 idles 3 cycles, then presents 0A with m_ready=1.
  - Required: 0A transfers, timeout_pulse stays 0, release is normal.
- Reset mid-line: assert rst asynchronously after 2 of 4 bytes.
  - Required: grant=00, m_valid=0, timeout_pulse=0 immediately.
  - After release, s0 re-sends from the start and is granted first (last=1).
